mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit. Consumes the EX/MEM pipeline register outputs: address, store data, LSU op and read/write strobes.
- Drives a request/grant/rvalid data-memory bus and returns formatted load data to the MEM/WB path.
- Holds the pipeline through `stall_o` until each access completes, is rejected, or times out.

---
 rtl/mem_stage_lsu.sv | 194 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns EX/MEM load/store requests into
// req/gnt/rvalid data-bus transactions and returns formatted load data.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  lsu_op_i,
  input  logic        mem_rd_sig_i,
  input  logic        mem_wr_sig_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic [1:0]  err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TO_EN  = (TIMEOUT_CYCLES != 0);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_timeout;
  logic              r_req;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [2:0]        r_op;
  logic [1:0]        r_lane;
  logic [31:0]       r_load;
  logic [1:0]        r_err;
  logic [1:0]        w_err_nxt;
  logic              w_access;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_accept;
  logic [3:0]        w_st_be;
  logic [31:0]       w_st_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld_fmt;

  assign w_access  = mem_rd_sig_i | mem_wr_sig_i;
  assign w_illegal = (mem_rd_sig_i & mem_wr_sig_i)
                   | (mem_wr_sig_i & ~((lsu_op_i == 3'b000) | (lsu_op_i == 3'b001) |
                                       (lsu_op_i == 3'b010)))
                   | (mem_rd_sig_i & ((lsu_op_i == 3'b011) | (lsu_op_i[2:1] == 2'b11)));
  assign w_misalign = ((lsu_op_i[1:0] == 2'b01) & addr_i[0])
                    | ((lsu_op_i == 3'b010) & (addr_i[1:0] != 2'b00));
  assign w_accept  = (r_state == S_IDLE) & w_access & ~w_illegal & ~w_misalign;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = TO_EN && (w_cnt_inc == TO_VAL);

  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = rs2_i;
    case (lsu_op_i[1:0])
      2'b00: begin
        w_st_be    = 4'b0001 << addr_i[1:0];
        w_st_wdata = {4{rs2_i[7:0]}};
      end
      2'b01: begin
        w_st_be    = 4'b0011 << addr_i[1:0];
        w_st_wdata = {2{rs2_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata_i[7:0];
    case (r_lane)
      2'd1:    w_byte = dmem_rdata_i[15:8];
      2'd2:    w_byte = dmem_rdata_i[23:16];
      2'd3:    w_byte = dmem_rdata_i[31:24];
      default: w_byte = dmem_rdata_i[7:0];
    endcase
    w_half = r_lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (r_op)
      3'b000:  w_ld_fmt = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_fmt = {24'h0, w_byte};
      3'b001:  w_ld_fmt = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_fmt = {16'h0, w_half};
      default: w_ld_fmt = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Error code is produced alongside the transition into DONE so it lands in r_err exactly then.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_illegal) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 2'b10;
          end else if (w_misalign) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 2'b01;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          w_state_nxt = r_we ? S_DONE : S_WAIT_R;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 2'b11;
        end
      end
      S_WAIT_R: begin
        if (dmem_rvalid_i) begin
          w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 2'b11;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done_o  = (r_state == S_DONE);
    stall_o = reset_n & w_access & (r_state != S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_op    <= '0;
      r_lane  <= '0;
      r_load  <= '0;
      r_err   <= '0;
    end else begin
      r_err  <= w_err_nxt;
      r_load <= ((r_state == S_WAIT_R) && dmem_rvalid_i) ? w_ld_fmt : '0;
      case (r_state)
        S_REQ:    r_cnt <= dmem_gnt_i ? '0 : w_cnt_inc;
        S_WAIT_R: r_cnt <= w_cnt_inc;
        default:  r_cnt <= '0;
      endcase
      if (w_accept) begin
        r_req   <= 1'b1;
        r_we    <= mem_wr_sig_i;
        r_addr  <= {addr_i[31:2], 2'b00};
        r_be    <= mem_wr_sig_i ? w_st_be : 4'b1111;
        r_wdata <= mem_wr_sig_i ? w_st_wdata : '0;
        r_op    <= lsu_op_i;
        r_lane  <= addr_i[1:0];
      end else if ((r_state == S_REQ) && (dmem_gnt_i || w_timeout)) begin
        r_req <= 1'b0;
      end
    end
  end

  assign load_data_o  = r_load;
  assign err_o        = r_err;
  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a small cycle-stepped bus responder.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic [31:0] rs2;
  logic [2:0]  lsu_op;
  logic        mem_rd_sig;
  logic        mem_wr_sig;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  int          t_stall;
  int          t_req;
  bit          t_done;
  bit          t_stable;
  logic [1:0]  t_err;
  logic [31:0] t_ld;
  logic        t_req_at_done;
  logic        t_stall_at_done;
  logic [31:0] t_addr;
  logic [3:0]  t_be;
  logic [31:0] t_wdata;
  logic        t_we;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .addr_i       (addr),
    .rs2_i        (rs2),
    .lsu_op_i     (lsu_op),
    .mem_rd_sig_i (mem_rd_sig),
    .mem_wr_sig_i (mem_wr_sig),
    .stall_o      (stall),
    .done_o       (done),
    .load_data_o  (load_data),
    .err_o        (err),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_be_o    (dmem_be),
    .dmem_wdata_o (dmem_wdata),
    .dmem_gnt_i   (dmem_gnt),
    .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  // Called just after a falling edge. gnt_dly counts REQ cycles before grant (>=20 means never).
  task automatic run_acc(input string tag, input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d, input int gnt_dly,
                         input bit rv_en, input logic [31:0] rd_data);
    bit gnt_prev_rd = 0;
    t_stall = 0; t_req = 0; t_done = 0; t_stable = 1; t_err = '0; t_ld = '0;
    t_req_at_done = 1'b0; t_stall_at_done = 1'b0;
    t_addr = '0; t_be = '0; t_wdata = '0; t_we = 1'b0;
    mem_rd_sig = rd; mem_wr_sig = wr; lsu_op = op; addr = a; rs2 = d;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        t_done = 1; t_err = err; t_ld = load_data;
        t_req_at_done = dmem_req; t_stall_at_done = stall;
        break;
      end
      if (stall) t_stall++;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      if (gnt_prev_rd && rv_en) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rd_data;
      end
      gnt_prev_rd = 0;
      if (dmem_req) begin
        if (t_req == 0) begin
          t_addr = dmem_addr; t_be = dmem_be; t_wdata = dmem_wdata; t_we = dmem_we;
        end else if (dmem_addr !== t_addr || dmem_be !== t_be ||
                     dmem_wdata !== t_wdata || dmem_we !== t_we) begin
          t_stable = 0;
        end
        if (t_req == gnt_dly) begin
          dmem_gnt    = 1'b1;
          gnt_prev_rd = !dmem_we;
        end
        t_req++;
      end
      @(negedge clk); #1;
    end
    mem_rd_sig = 1'b0; mem_wr_sig = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    chk({tag, "_done"}, 32'(t_done), 32'd1);
    chk({tag, "_stall_at_done"}, 32'(t_stall_at_done), 32'd0);
    @(negedge clk); #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    addr = '0; rs2 = '0; lsu_op = '0; mem_rd_sig = 1'b0; mem_wr_sig = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    reset_n = 1'b1;
    @(negedge clk); #1;

    run_acc("lb", 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 1'b1, 32'h80FF_FF7F);
    chk("lb_stall", t_stall, 3);
    chk("lb_req", t_req, 1);
    chk("lb_addr", t_addr, 32'h0000_1000);
    chk("lb_be", 32'(t_be), 32'hF);
    chk("lb_we", 32'(t_we), 32'd0);
    chk("lb_ld", t_ld, 32'hFFFF_FF80);
    chk("lb_err", 32'(t_err), 32'd0);

    run_acc("sh", 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 3, 1'b0, 32'h0);
    chk("sh_req_cycles", t_req, 4);
    chk("sh_stable", 32'(t_stable), 32'd1);
    chk("sh_addr", t_addr, 32'h0000_2000);
    chk("sh_be", 32'(t_be), 32'hC);
    chk("sh_wdata", t_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(t_we), 32'd1);
    chk("sh_stall", t_stall, 5);
    chk("sh_err", 32'(t_err), 32'd0);
    chk("sh_ld", t_ld, 32'd0);

    run_acc("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 0, 1'b1, 32'h0);
    chk("lw_mis_req", t_req, 0);
    chk("lw_mis_stall", t_stall, 1);
    chk("lw_mis_err", 32'(t_err), 32'd1);
    chk("lw_mis_ld", t_ld, 32'd0);

    run_acc("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'h0, 0, 1'b1, 32'hBEEF_0000);
    chk("lhu_ld", t_ld, 32'h0000_BEEF);
    chk("lhu_addr", t_addr, 32'h0000_3000);
    chk("lhu_err", 32'(t_err), 32'd0);
    chk("lhu_stall", t_stall, 3);

    run_acc("lh", 1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 0, 1'b1, 32'h8001_1234);
    chk("lh_ld", t_ld, 32'hFFFF_8001);

    run_acc("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0501, 32'h0000_00A5, 0, 1'b0, 32'h0);
    chk("sb_be", 32'(t_be), 32'h2);
    chk("sb_wdata", t_wdata, 32'hA5A5_A5A5);
    chk("sb_stall", t_stall, 2);

    run_acc("rdwr", 1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 0, 1'b1, 32'h0);
    chk("rdwr_err", 32'(t_err), 32'd2);
    chk("rdwr_req", t_req, 0);

    run_acc("st_bu", 1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0, 0, 1'b0, 32'h0);
    chk("st_bu_err", 32'(t_err), 32'd2);
    chk("st_bu_req", t_req, 0);

    run_acc("to_gnt", 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 99, 1'b0, 32'h0);
    chk("to_gnt_req", t_req, 4);
    chk("to_gnt_err", 32'(t_err), 32'd3);
    chk("to_gnt_req_drop", 32'(t_req_at_done), 32'd0);
    chk("to_gnt_stall", t_stall, 5);
    chk("to_gnt_ld", t_ld, 32'd0);

    run_acc("to_rv", 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 0, 1'b0, 32'h0);
    chk("to_rv_req", t_req, 1);
    chk("to_rv_err", 32'(t_err), 32'd3);
    chk("to_rv_stall", t_stall, 6);

    // Reset in WAIT_R with the load request still asserted.
    mem_rd_sig = 1'b1; lsu_op = 3'b010; addr = 32'h0000_0040;
    @(negedge clk); #1;
    chk("mid_req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk); #1;
    dmem_gnt = 1'b0;
    chk("mid_wait_stall", 32'(stall), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_we", 32'(dmem_we), 32'd0);
    chk("mid_rst_addr", dmem_addr, 32'd0);
    chk("mid_rst_be", 32'(dmem_be), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    mem_rd_sig = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk); #1;

    run_acc("sw", 1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    chk("sw_be", 32'(t_be), 32'hF);
    chk("sw_wdata", t_wdata, 32'hDEAD_BEEF);
    chk("sw_addr", t_addr, 32'h0000_0010);
    chk("sw_err", 32'(t_err), 32'd0);
    chk("sw_stall", t_stall, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
